// File: rtl/inference_sequencer_if.sv
// Control/status bundle between a host and the inference sequencer.
// The host drives launch/abort and per-stage done; the sequencer drives the rest.
interface inference_sequencer_if #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned STAGE_W    = 2
);
  logic                  start;
  logic                  abort;
  logic [NUM_STAGES-1:0] stage_done;
  logic [NUM_STAGES-1:0] stage_rstn;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [STAGE_W-1:0]    cur_stage;
  logic [31:0]           cycle_count;

  modport master (
    output start, abort, stage_done,
    input  stage_rstn, busy, done, error, cur_stage, cycle_count
  );

  modport slave (
    input  start, abort, stage_done,
    output stage_rstn, busy, done, error, cur_stage, cycle_count
  );
endinterface

// File: rtl/inference_sequencer.sv
// Releases a chain of layer blocks from reset one at a time, advancing on each
// stage's done, with a per-stage timeout, abort, and a CLEAR+RUN cycle counter.
module inference_sequencer #(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned STAGE_W    = 2,
    parameter int unsigned TIMEOUT    = 100000,
    parameter int unsigned RST_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst,
    inference_sequencer_if.slave bus
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned CLR_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, HOLD, FAULT} state_t;

    state_t                state_q, state_d;
    logic [NUM_STAGES-1:0] stage_rstn_q, stage_rstn_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [STAGE_W-1:0]    cur_stage_q, cur_stage_d;
    logic [31:0]           cycle_count_q, cycle_count_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [CLR_W-1:0]      clr_cnt_q, clr_cnt_d;
    logic [31:0]           count_inc;

    always_comb begin
        state_d       = state_q;
        stage_rstn_d  = stage_rstn_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        error_d       = error_q;
        cur_stage_d   = cur_stage_q;
        cycle_count_d = cycle_count_q;
        timer_d       = timer_q;
        clr_cnt_d     = clr_cnt_q;
        count_inc     = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 32'd1;

        case (state_q)
            IDLE, HOLD, FAULT: begin
                if (bus.start) begin
                    state_d       = CLEAR;
                    stage_rstn_d  = '0;
                    busy_d        = 1'b1;
                    error_d       = 1'b0;
                    cur_stage_d   = '0;
                    cycle_count_d = '0;
                    clr_cnt_d     = '0;
                end
            end
            CLEAR: begin
                cycle_count_d = count_inc;
                if (bus.abort) begin
                    state_d      = IDLE;
                    stage_rstn_d = '0;
                    busy_d       = 1'b0;
                end else if (clr_cnt_q == CLR_W'(RST_CYCLES - 1)) begin
                    state_d      = RUN;
                    stage_rstn_d = {stage_rstn_q[NUM_STAGES-2:0], 1'b1};
                    timer_d      = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            RUN: begin
                cycle_count_d = count_inc;
                // abort beats stage done, which beats timeout on the same cycle
                if (bus.abort) begin
                    state_d      = IDLE;
                    stage_rstn_d = '0;
                    busy_d       = 1'b0;
                end else if (bus.stage_done[cur_stage_q]) begin
                    if (cur_stage_q == STAGE_W'(NUM_STAGES - 1)) begin
                        state_d = HOLD;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cur_stage_d  = cur_stage_q + STAGE_W'(1);
                        stage_rstn_d = {stage_rstn_q[NUM_STAGES-2:0], 1'b1};
                        timer_d      = '0;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d      = FAULT;
                    stage_rstn_d = '0;
                    busy_d       = 1'b0;
                    error_d      = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d      = IDLE;
                stage_rstn_d = '0;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            stage_rstn_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            cur_stage_q   <= '0;
            cycle_count_q <= '0;
            timer_q       <= '0;
            clr_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            stage_rstn_q  <= stage_rstn_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            cur_stage_q   <= cur_stage_d;
            cycle_count_q <= cycle_count_d;
            timer_q       <= timer_d;
            clr_cnt_q     <= clr_cnt_d;
        end
    end

    assign bus.stage_rstn  = stage_rstn_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.cur_stage   = cur_stage_q;
    assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed table-driven bench for inference_sequencer (4 stages, timeout 16,
// 2 clear cycles); each row holds inputs for n edges, then checks all outputs.
module tb_inference_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    inference_sequencer_if #(.NUM_STAGES(4), .STAGE_W(2)) bus ();

    inference_sequencer #(
        .NUM_STAGES(4),
        .STAGE_W   (2),
        .TIMEOUT   (16),
        .RST_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic        abort;
        logic [3:0]  sd;
        int unsigned n;
        logic [3:0]  rstn;
        logic        busy;
        logic        done;
        logic        err;
        logic [1:0]  cur;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;

    always @(negedge clk) if (bus.done === 1'b1) done_seen++;

    task automatic v(input logic r, input logic s, input logic a, input logic [3:0] sd,
                     input int unsigned n, input logic [3:0] rstn, input logic busy,
                     input logic done, input logic err, input logic [1:0] cur,
                     input logic [31:0] cnt);
        vec_t e;
        e.rst = r; e.start = s; e.abort = a; e.sd = sd; e.n = n;
        e.rstn = rstn; e.busy = busy; e.done = done; e.err = err; e.cur = cur; e.cnt = cnt;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.stage_done = '0;

        //  rst st ab sd      n   rstn    busy dn er cur cnt
        // reset, then nominal run: stages done on RUN cycle 5,3,7,2
        v(1, 0, 0, 4'b0000, 2,  4'b0000, 0, 0, 0, 0, 0);   // 0
        v(0, 1, 0, 4'b0000, 1,  4'b0000, 1, 0, 0, 0, 0);   // 1 CLEAR
        v(0, 0, 0, 4'b0000, 1,  4'b0000, 1, 0, 0, 0, 1);   // 2 CLEAR
        v(0, 0, 0, 4'b0000, 1,  4'b0001, 1, 0, 0, 0, 2);   // 3 RUN s0
        v(0, 0, 0, 4'b0000, 4,  4'b0001, 1, 0, 0, 0, 6);   // 4
        v(0, 0, 0, 4'b0001, 1,  4'b0011, 1, 0, 0, 1, 7);   // 5 s1
        v(0, 0, 0, 4'b0000, 2,  4'b0011, 1, 0, 0, 1, 9);   // 6
        v(0, 0, 0, 4'b0010, 1,  4'b0111, 1, 0, 0, 2, 10);  // 7 s2
        v(0, 0, 0, 4'b0000, 6,  4'b0111, 1, 0, 0, 2, 16);  // 8
        v(0, 0, 0, 4'b0100, 1,  4'b1111, 1, 0, 0, 3, 17);  // 9 s3
        v(0, 0, 0, 4'b0000, 1,  4'b1111, 1, 0, 0, 3, 18);  // 10
        v(0, 0, 0, 4'b1000, 1,  4'b1111, 0, 1, 0, 3, 19);  // 11 HOLD, done
        v(0, 0, 0, 4'b0000, 1,  4'b1111, 0, 0, 0, 3, 19);  // 12
        v(0, 0, 1, 4'b0000, 1,  4'b1111, 0, 0, 0, 3, 19);  // 13 abort ignored in HOLD
        // restart from HOLD; start ignored in CLEAR and RUN
        v(0, 1, 0, 4'b0000, 1,  4'b0000, 1, 0, 0, 0, 0);   // 14
        v(0, 1, 0, 4'b0000, 1,  4'b0000, 1, 0, 0, 0, 1);   // 15
        v(0, 0, 0, 4'b0000, 1,  4'b0001, 1, 0, 0, 0, 2);   // 16
        v(0, 1, 0, 4'b0000, 3,  4'b0001, 1, 0, 0, 0, 5);   // 17
        // timeout in stage 2
        v(0, 0, 0, 4'b0001, 1,  4'b0011, 1, 0, 0, 1, 6);   // 18
        v(0, 0, 0, 4'b0010, 1,  4'b0111, 1, 0, 0, 2, 7);   // 19
        v(0, 0, 0, 4'b0000, 15, 4'b0111, 1, 0, 0, 2, 22);  // 20 15 RUN cycles, no fault yet
        v(0, 0, 0, 4'b0000, 1,  4'b0000, 0, 0, 1, 2, 23);  // 21 16th -> FAULT
        v(0, 0, 0, 4'b0000, 3,  4'b0000, 0, 0, 1, 2, 23);  // 22
        v(0, 0, 1, 4'b0000, 1,  4'b0000, 0, 0, 1, 2, 23);  // 23 abort ignored in FAULT
        v(0, 1, 0, 4'b0000, 1,  4'b0000, 1, 0, 0, 0, 0);   // 24 start clears error
        // abort during stage 1; stale stage_done[0] ignored
        v(0, 0, 0, 4'b0000, 1,  4'b0000, 1, 0, 0, 0, 1);   // 25
        v(0, 0, 0, 4'b0000, 1,  4'b0001, 1, 0, 0, 0, 2);   // 26
        v(0, 0, 0, 4'b0001, 1,  4'b0011, 1, 0, 0, 1, 3);   // 27
        v(0, 0, 0, 4'b0001, 2,  4'b0011, 1, 0, 0, 1, 5);   // 28
        v(0, 0, 1, 4'b0000, 1,  4'b0000, 0, 0, 0, 1, 6);   // 29 -> IDLE
        v(0, 0, 0, 4'b0000, 3,  4'b0000, 0, 0, 0, 1, 6);   // 30 count frozen
        // race: stage 1 done on its 16th RUN cycle
        v(0, 1, 0, 4'b0000, 1,  4'b0000, 1, 0, 0, 0, 0);   // 31
        v(0, 0, 0, 4'b0000, 2,  4'b0001, 1, 0, 0, 0, 2);   // 32
        v(0, 0, 0, 4'b0001, 1,  4'b0011, 1, 0, 0, 1, 3);   // 33
        v(0, 0, 0, 4'b0001, 15, 4'b0011, 1, 0, 0, 1, 18);  // 34
        v(0, 0, 0, 4'b0010, 1,  4'b0111, 1, 0, 0, 2, 19);  // 35 done wins
        v(0, 0, 0, 4'b0000, 1,  4'b0111, 1, 0, 0, 2, 20);  // 36
        // reset mid-run in stage 3; rst beats start
        v(0, 0, 0, 4'b0100, 1,  4'b1111, 1, 0, 0, 3, 21);  // 37
        v(1, 0, 0, 4'b0000, 1,  4'b0000, 0, 0, 0, 0, 0);   // 38
        v(1, 1, 1, 4'b0000, 3,  4'b0000, 0, 0, 0, 0, 0);   // 39
        v(0, 0, 0, 4'b0000, 2,  4'b0000, 0, 0, 0, 0, 0);   // 40

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            bus.start = tbl[i].start;
            bus.abort = tbl[i].abort;
            bus.stage_done = tbl[i].sd;
            repeat (tbl[i].n) @(posedge clk);
            #1;
            chk($sformatf("row%0d stage_rstn", i),  32'(bus.stage_rstn),  32'(tbl[i].rstn));
            chk($sformatf("row%0d busy", i),        32'(bus.busy),        32'(tbl[i].busy));
            chk($sformatf("row%0d done", i),        32'(bus.done),        32'(tbl[i].done));
            chk($sformatf("row%0d error", i),       32'(bus.error),       32'(tbl[i].err));
            chk($sformatf("row%0d cur_stage", i),   32'(bus.cur_stage),   32'(tbl[i].cur));
            chk($sformatf("row%0d cycle_count", i), bus.cycle_count,      tbl[i].cnt);
        end
        chk("done_pulses_after_table", 32'(done_seen), 32'd1);

        // hand sequence: every stage completes on its first RUN cycle
        begin
            bit got = 1'b0;
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.stage_done = 4'b1111;
            for (int c = 0; c < 40 && !got; c++) begin
                @(posedge clk); #1;
                if (bus.done === 1'b1) got = 1'b1;
            end
            chk("fast_run_done_seen", 32'(got), 32'd1);
            chk("fast_run_cycle_count", bus.cycle_count, 32'd6);
            chk("fast_run_rstn", 32'(bus.stage_rstn), 32'hF);
            bus.stage_done = '0;
            @(posedge clk); #1;
            chk("fast_run_done_one_cycle", 32'(bus.done), 32'd0);
            chk("done_pulses_total", 32'(done_seen), 32'd2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
